czono_linear_map_seq: RTL and testbench

Sequential, multi-lane linear-image engine for constrained zonotopes: computes OUT.c = R·Z.c and OUT.G = R·Z.G over memory-mapped operands. It replaces the free-running combinational-indexed linear image with a start/done handshake, latched dimensions, LANES-wide generator parallelism, defined fixed-point arithmetic and dimension checking. It sits between the CZonotope operand memories and the result memory in the set-operation datapath. Z.A, Z.b are not touched; the caller aliases them into OUT.

---
 rtl/czono_linear_map_seq_if.sv | 58 +++++
 rtl/czono_linear_map_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_czono_linear_map_seq.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/czono_linear_map_seq_if.sv
// Control, operand-read and result-write bundle of czono_linear_map_seq.
// slave = engine side, master = controller/memory side.
interface czono_linear_map_seq_if #(
   parameter int NMAX       = 512,
   parameter int NGMAX      = 512,
   parameter int NRMAX      = 512,
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 4
);
   localparam int NRW = $clog2(NRMAX) + 1;
   localparam int NW  = $clog2(NMAX) + 1;
   localparam int NGW = $clog2(NGMAX) + 1;
   localparam int NRA = $clog2(NRMAX);
   localparam int NA  = $clog2(NMAX);
   localparam int CA  = $clog2(NGMAX + 1);
   localparam int LW  = LANES * DATA_WIDTH;

   logic                  start_i;
   logic [NRW-1:0]        r_nr_i;
   logic [NW-1:0]         r_n_i;
   logic [NW-1:0]         z_n_i;
   logic [NGW-1:0]        z_ng_i;
   logic [NGW-1:0]        z_nc_i;
   logic [NRA-1:0]        r_rd_row_o;
   logic [NA-1:0]         r_rd_col_o;
   logic [DATA_WIDTH-1:0] r_rd_data_i;
   logic [NA-1:0]         z_rd_row_o;
   logic [CA-1:0]         z_rd_col_o;
   logic [LW-1:0]         z_rd_data_i;
   logic [LANES-1:0]      out_we_o;
   logic [NRA-1:0]        out_row_o;
   logic [CA-1:0]         out_col_o;
   logic [LW-1:0]         out_data_o;
   logic [NRW-1:0]        out_n_o;
   logic [NGW-1:0]        out_ng_o;
   logic [NGW-1:0]        out_nc_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  err_o;

   modport slave (
      input  start_i, r_nr_i, r_n_i, z_n_i, z_ng_i, z_nc_i,
      input  r_rd_data_i, z_rd_data_i,
      output r_rd_row_o, r_rd_col_o, z_rd_row_o, z_rd_col_o,
      output out_we_o, out_row_o, out_col_o, out_data_o,
      output out_n_o, out_ng_o, out_nc_o,
      output busy_o, done_o, err_o
   );

   modport master (
      output start_i, r_nr_i, r_n_i, z_n_i, z_ng_i, z_nc_i,
      output r_rd_data_i, z_rd_data_i,
      input  r_rd_row_o, r_rd_col_o, z_rd_row_o, z_rd_col_o,
      input  out_we_o, out_row_o, out_col_o, out_data_o,
      input  out_n_o, out_ng_o, out_nc_o,
      input  busy_o, done_o, err_o
   );
endinterface

// File: rtl/czono_linear_map_seq.sv
// Sequential LANES-wide linear image OUT.[c|G] = R * Z.[c|G] in fixed point.
// Define CZONO_LINMAP_SAT_EN to saturate results instead of wrapping.
module czono_linear_map_seq #(
   parameter int NMAX       = 512,
   parameter int NGMAX      = 512,
   parameter int NRMAX      = 512,
   parameter int DATA_WIDTH = 32,
   parameter int FRAC_BITS  = 16,
   parameter int LANES      = 4
) (
   input logic                   clk_i,
   input logic                   rst_i,
   czono_linear_map_seq_if.slave bus
);
   localparam int W   = DATA_WIDTH;
   localparam int NRW = $clog2(NRMAX) + 1;
   localparam int NW  = $clog2(NMAX) + 1;
   localparam int NGW = $clog2(NGMAX) + 1;
   localparam int NRA = $clog2(NRMAX);
   localparam int NA  = $clog2(NMAX);
   localparam int CA  = $clog2(NGMAX + 1);
   localparam int LW  = LANES * W;
   localparam int PW  = 2 * W;
   localparam int AW  = 2 * W + $clog2(NMAX);

`ifdef CZONO_LINMAP_SAT_EN
   localparam logic signed [AW-1:0] SMAX =
      AW'({1'b0, {(W-1){1'b1}}});
   localparam logic signed [AW-1:0] SMIN =
      {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [NRW-1:0]       nr_q, nr_d;
   logic [NW-1:0]        n_q, n_d;
   logic [NGW-1:0]       ng_q, ng_d;
   logic [NGW-1:0]       nc_q, nc_d;
   logic                 err_q, err_d;
   logic [NRA-1:0]       row_q, row_d;
   logic [NA-1:0]        k_q, k_d;
   logic [CA-1:0]        cb_q, cb_d;
   logic [NRA-1:0]       orow_q;
   logic [CA-1:0]        ocol_q;
   logic [LW-1:0]        odata_q;
   logic [LW-1:0]        res;
   logic signed [AW-1:0] acc_q [LANES];
   logic signed [PW-1:0] prod [LANES];
   logic [LANES-1:0]     we;
   logic                 dim_bad;
   logic                 k_last;
   logic                 row_last;
   logic                 blk_last;
   logic                 acc_clr;
   logic                 acc_en;

   assign dim_bad = (bus.r_n_i != bus.z_n_i)
                 || (bus.z_n_i == '0)
                 || (bus.r_nr_i == '0)
                 || (int'(bus.z_n_i) > NMAX)
                 || (int'(bus.r_nr_i) > NRMAX)
                 || (int'(bus.z_ng_i) > NGMAX);

   assign k_last   = int'(k_q) == int'(n_q) - 1;
   assign row_last = int'(row_q) == int'(nr_q) - 1;
   assign blk_last = int'(cb_q) + LANES > int'(ng_q);

   // Data for the k=0 issue is stale, so that cycle clears instead.
   assign acc_clr = (state_q == S_ISSUE) && (k_q == '0);
   assign acc_en  = ((state_q == S_ISSUE) && (k_q != '0))
                 || (state_q == S_DRAIN);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      nr_d    = nr_q;
      n_d     = n_q;
      ng_d    = ng_q;
      nc_d    = nc_q;
      err_d   = err_q;
      row_d   = row_q;
      k_d     = k_q;
      cb_d    = cb_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               nr_d  = bus.r_nr_i;
               n_d   = bus.z_n_i;
               ng_d  = bus.z_ng_i;
               nc_d  = bus.z_nc_i;
               err_d = dim_bad;
               if (dim_bad) begin
                  state_d = S_DONE;
               end else begin
                  row_d   = '0;
                  k_d     = '0;
                  cb_d    = '0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            if (k_last) begin
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + NA'(1);
            end
         end
         S_DRAIN: begin
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (!blk_last) begin
               k_d     = '0;
               cb_d    = cb_q + CA'(LANES);
               state_d = S_ISSUE;
            end else if (!row_last) begin
               k_d     = '0;
               cb_d    = '0;
               row_d   = row_q + NRA'(1);
               state_d = S_ISSUE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         prod[l] = PW'($signed(bus.r_rd_data_i))
                 * PW'($signed(bus.z_rd_data_i[l*W +: W]));
      end
   end

   always_comb begin
      logic signed [AW-1:0] shf;
      shf = '0;
      res = '0;
      for (int l = 0; l < LANES; l++) begin
         shf = acc_q[l] >>> FRAC_BITS;
`ifdef CZONO_LINMAP_SAT_EN
         if (shf > SMAX) begin
            res[l*W +: W] = {1'b0, {(W-1){1'b1}}};
         end else if (shf < SMIN) begin
            res[l*W +: W] = {1'b1, {(W-1){1'b0}}};
         end else begin
            res[l*W +: W] = shf[W-1:0];
         end
`else
         res[l*W +: W] = shf[W-1:0];
`endif
      end
   end

   // Lanes past the last generator column are never written.
   always_comb begin
      we = '0;
      for (int l = 0; l < LANES; l++) begin
         we[l] = (state_q == S_WRITE)
              && (int'(cb_q) + l <= int'(ng_q));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         nr_q    <= '0;
         n_q     <= '0;
         ng_q    <= '0;
         nc_q    <= '0;
         err_q   <= 1'b0;
         row_q   <= '0;
         k_q     <= '0;
         cb_q    <= '0;
         orow_q  <= '0;
         ocol_q  <= '0;
         odata_q <= '0;
         for (int l = 0; l < LANES; l++) begin
            acc_q[l] <= '0;
         end
      end else begin
         nr_q  <= nr_d;
         n_q   <= n_d;
         ng_q  <= ng_d;
         nc_q  <= nc_d;
         err_q <= err_d;
         row_q <= row_d;
         k_q   <= k_d;
         cb_q  <= cb_d;
         if (state_q == S_WRITE) begin
            orow_q  <= row_q;
            ocol_q  <= cb_q;
            odata_q <= res;
         end
         for (int l = 0; l < LANES; l++) begin
            if (acc_clr) begin
               acc_q[l] <= '0;
            end else if (acc_en) begin
               acc_q[l] <= acc_q[l] + AW'(prod[l]);
            end
         end
      end
   end

   assign bus.r_rd_row_o = row_q;
   assign bus.r_rd_col_o = k_q;
   assign bus.z_rd_row_o = k_q;
   assign bus.z_rd_col_o = cb_q;

   assign bus.out_we_o   = we;
   assign bus.out_row_o  = (state_q == S_WRITE) ? row_q : orow_q;
   assign bus.out_col_o  = (state_q == S_WRITE) ? cb_q : ocol_q;
   assign bus.out_data_o = (state_q == S_WRITE) ? res : odata_q;

   assign bus.out_n_o  = nr_q;
   assign bus.out_ng_o = ng_q;
   assign bus.out_nc_o = nc_q;

   assign bus.busy_o = (state_q != S_IDLE);
   assign bus.done_o = (state_q == S_DONE);
   assign bus.err_o  = (state_q == S_DONE) && err_q;
endmodule

// File: tb/tb_czono_linear_map_seq.sv
// Directed bench for czono_linear_map_seq: memory models, write scoreboard,
// cycle counts, error path, busy/DONE start filtering and mid-op reset.
module tb_czono_linear_map_seq;
   localparam int W  = 32;
   localparam int L  = 4;
   localparam int LW = L * W;

   typedef struct {
      int           row;
      int           col;
      logic [L-1:0] we;
      logic [LW-1:0] data;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] rm [8][8];
   logic [31:0] zm [8][16];
   exp_t        q [$];
   exp_t        me;
   logic [LW-1:0] mm;

   always #5 clk_i = ~clk_i;

   czono_linear_map_seq_if #(
      .NMAX(512), .NGMAX(512), .NRMAX(512),
      .DATA_WIDTH(W), .LANES(L)
   ) bus ();

   czono_linear_map_seq #(
      .NMAX(512), .NGMAX(512), .NRMAX(512),
      .DATA_WIDTH(W), .FRAC_BITS(16), .LANES(L)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .bus(bus)
   );

   task automatic chk(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fx(real v);
      return 32'(longint'(v * 65536.0));
   endfunction

   function automatic logic [31:0] rd_r(int r, int c);
      if (r < 8 && c < 8) return rm[r][c];
      return '0;
   endfunction

   function automatic logic [31:0] rd_z(int r, int c);
      if (r < 8 && c < 16) return zm[r][c];
      return '0;
   endfunction

   function automatic logic [31:0] model(int r, int j, int n);
      logic signed [79:0] acc;
      logic signed [79:0] s;
      acc = '0;
      for (int k = 0; k < n; k++) begin
         acc += 80'($signed(rm[r][k])) * 80'($signed(zm[k][j]));
      end
      s = acc >>> 16;
`ifdef CZONO_LINMAP_SAT_EN
      if (s > 80'sd2147483647) return 32'h7FFF_FFFF;
      if (s < -80'sd2147483648) return 32'h8000_0000;
`endif
      return s[31:0];
   endfunction

   always @(posedge clk_i) begin
      bus.r_rd_data_i <= rd_r(int'(bus.r_rd_row_o), int'(bus.r_rd_col_o));
      for (int l = 0; l < L; l++) begin
         bus.z_rd_data_i[l*W +: W] <=
            rd_z(int'(bus.z_rd_row_o), int'(bus.z_rd_col_o) + l);
      end
   end

   always @(negedge clk_i) begin
      if (bus.out_we_o !== '0) begin
         chk("write_expected", LW'(q.size() != 0), LW'(1));
         if (q.size() != 0) begin
            me = q.pop_front();
            mm = '0;
            for (int l = 0; l < L; l++) begin
               if (me.we[l]) mm[l*W +: W] = '1;
            end
            chk("wr_row", LW'(bus.out_row_o), LW'(me.row));
            chk("wr_col", LW'(bus.out_col_o), LW'(me.col));
            chk("wr_we", LW'(bus.out_we_o), LW'(me.we));
            chk("wr_data", bus.out_data_o & mm, me.data & mm);
         end
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) rm[i][j] = '0;
         for (int j = 0; j < 16; j++) zm[i][j] = '0;
      end
   endtask

   task automatic set_dims(int nr, int rn, int zn, int ng, int nc);
      bus.r_nr_i = 10'(nr);
      bus.r_n_i  = 10'(rn);
      bus.z_n_i  = 10'(zn);
      bus.z_ng_i = 10'(ng);
      bus.z_nc_i = 10'(nc);
   endtask

   task automatic push_exp(int r, int c, logic [L-1:0] we, logic [LW-1:0] d);
      exp_t e;
      e.row  = r;
      e.col  = c;
      e.we   = we;
      e.data = d;
      q.push_back(e);
   endtask

   task automatic push_model(int nr, int n, int ng);
      exp_t e;
      for (int r = 0; r < nr; r++) begin
         for (int cb = 0; cb <= ng; cb += L) begin
            e.row  = r;
            e.col  = cb;
            e.we   = '0;
            e.data = '0;
            for (int l = 0; l < L; l++) begin
               if (cb + l <= ng) begin
                  e.we[l] = 1'b1;
                  e.data[l*W +: W] = model(r, cb + l, n);
               end
            end
            q.push_back(e);
         end
      end
   endtask

   task automatic run_op(input int pulse_at, input bit start_in_done,
                         output int cyc);
      @(negedge clk_i);
      bus.start_i = 1'b1;
      @(negedge clk_i);
      bus.start_i = 1'b0;
      cyc = 1;
      chk("busy_after_start", LW'(bus.busy_o), LW'(1));
      while (bus.done_o !== 1'b1 && cyc < 500) begin
         @(negedge clk_i);
         cyc++;
         bus.start_i = (cyc == pulse_at);
      end
      if (start_in_done) bus.start_i = 1'b1;
   endtask

   task automatic finish_op(string tag);
      @(negedge clk_i);
      bus.start_i = 1'b0;
      chk({tag, "_done_pulse"}, LW'(bus.done_o), LW'(0));
      chk({tag, "_idle"}, LW'(bus.busy_o), LW'(0));
      chk({tag, "_all_written"}, LW'(q.size()), LW'(0));
   endtask

   task automatic setup_t1();
      clear_mem();
      rm[0][0] = fx(1.0);
      rm[1][1] = fx(1.0);
      zm[0][0] = fx(1.0);
      zm[1][0] = fx(-2.0);
      zm[0][1] = fx(0.5);
      zm[0][2] = fx(-1.5);
      zm[0][3] = fx(3.25);
      zm[1][1] = fx(2.0);
      zm[1][2] = fx(-0.75);
      zm[1][3] = fx(100.0);
      set_dims(2, 2, 2, 3, 1);
      push_exp(0, 0, 4'b1111, {zm[0][3], zm[0][2], zm[0][1], zm[0][0]});
      push_exp(1, 0, 4'b1111, {zm[1][3], zm[1][2], zm[1][1], zm[1][0]});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      bus.start_i = 1'b0;
      set_dims(0, 0, 0, 0, 0);
      clear_mem();
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("rst_busy", LW'(bus.busy_o), LW'(0));
      chk("rst_done", LW'(bus.done_o), LW'(0));
      chk("rst_err", LW'(bus.err_o), LW'(0));
      chk("rst_we", LW'(bus.out_we_o), LW'(0));
      chk("rst_raddr", LW'({bus.r_rd_row_o, bus.r_rd_col_o}), LW'(0));
      chk("rst_zaddr", LW'({bus.z_rd_row_o, bus.z_rd_col_o}), LW'(0));
      chk("rst_data", bus.out_data_o, LW'(0));
      chk("rst_dims", LW'({bus.out_n_o, bus.out_ng_o, bus.out_nc_o}), LW'(0));
      rst_i = 1'b0;

      // identity map, start pulse while busy
      setup_t1();
      run_op(3, 1'b0, cyc);
      chk("t1_cycles", LW'(cyc), LW'(9));
      chk("t1_err", LW'(bus.err_o), LW'(0));
      chk("t1_out_n", LW'(bus.out_n_o), LW'(2));
      chk("t1_out_ng", LW'(bus.out_ng_o), LW'(3));
      chk("t1_out_nc", LW'(bus.out_nc_o), LW'(1));
      finish_op("t1");

      // 1x2 map, lane 3 unused
      clear_mem();
      rm[0][0] = fx(2.0);
      rm[0][1] = fx(1.0);
      zm[0][0] = fx(0.5);
      zm[1][0] = fx(0.25);
      zm[0][1] = fx(1.0);
      zm[1][2] = fx(1.0);
      set_dims(1, 2, 2, 2, 0);
      push_exp(0, 0, 4'b0111,
               {32'h0, 32'h0001_0000, 32'h0002_0000, 32'h0001_4000});
      run_op(0, 1'b0, cyc);
      chk("t2_cycles", LW'(cyc), LW'(5));
      finish_op("t2");

      // ng=8: three column blocks per row, random operands
      clear_mem();
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 3; k++) begin
            rm[r][k] = 32'(int'($urandom_range(0, 524288)) - 262144);
         end
      end
      for (int k = 0; k < 3; k++) begin
         for (int j = 0; j < 9; j++) begin
            zm[k][j] = 32'(int'($urandom_range(0, 524288)) - 262144);
         end
      end
      set_dims(2, 3, 3, 8, 2);
      push_model(2, 3, 8);
      run_op(0, 1'b0, cyc);
      chk("t3_cycles", LW'(cyc), LW'(31));
      finish_op("t3");

      // overflow: saturate or wrap
      clear_mem();
      rm[0][0] = fx(32767.0);
      rm[0][1] = fx(32767.0);
      zm[0][0] = fx(32767.0);
      zm[1][0] = fx(32767.0);
      set_dims(1, 2, 2, 0, 0);
`ifdef CZONO_LINMAP_SAT_EN
      push_exp(0, 0, 4'b0001, LW'(32'h7FFF_FFFF));
`else
      push_exp(0, 0, 4'b0001, LW'(32'h0002_0000));
`endif
      run_op(0, 1'b0, cyc);
      chk("t4_cycles", LW'(cyc), LW'(5));
      finish_op("t4");

      // dimension mismatch, start held through DONE
      set_dims(1, 3, 2, 1, 0);
      run_op(0, 1'b1, cyc);
      chk("t5_cycles", LW'(cyc), LW'(1));
      chk("t5_err", LW'(bus.err_o), LW'(1));
      chk("t5_out_n", LW'(bus.out_n_o), LW'(1));
      @(negedge clk_i);
      chk("t5_start_in_done_ignored", LW'(bus.busy_o), LW'(0));
      bus.start_i = 1'b0;
      @(negedge clk_i);
      chk("t5_idle", LW'(bus.busy_o), LW'(0));
      chk("t5_no_writes", LW'(q.size()), LW'(0));

      // n=0 rejected
      set_dims(1, 0, 0, 1, 0);
      run_op(0, 1'b0, cyc);
      chk("t5b_cycles", LW'(cyc), LW'(1));
      chk("t5b_err", LW'(bus.err_o), LW'(1));
      finish_op("t5b");

      // reset during ISSUE of row 1
      setup_t1();
      @(negedge clk_i);
      bus.start_i = 1'b1;
      @(negedge clk_i);
      bus.start_i = 1'b0;
      repeat (4) @(negedge clk_i);
      chk("t6_row1_issue", LW'(bus.r_rd_row_o), LW'(1));
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("t6_busy_after_rst", LW'(bus.busy_o), LW'(0));
      chk("t6_we_after_rst", LW'(bus.out_we_o), LW'(0));
      chk("t6_row1_unwritten", LW'(q.size()), LW'(1));
      q.delete();
      repeat (6) @(negedge clk_i);
      chk("t6_stays_idle", LW'(bus.busy_o), LW'(0));

      setup_t1();
      run_op(0, 1'b0, cyc);
      chk("t6_restart_cycles", LW'(cyc), LW'(9));
      finish_op("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
